// File: rtl/rear_lights_sequencer_if.sv
// Control/config inputs and lamp outputs of the rear-light sequencer, grouped as one bundle.
// The slave modport is the sequencer; the master modport is the register block or a bench.
interface rear_lights_sequencer_if #(
    parameter int NUM_SEG  = 8,
    parameter int PWM_BITS = 8
);
    logic                ctl_tail_en;
    logic                ctl_brake;
    logic                ctl_left;
    logic                ctl_right;
    logic                ctl_hazard;
    logic [PWM_BITS-1:0] cfg_tail_duty;
    logic [PWM_BITS-1:0] cfg_brake_duty;
    logic [PWM_BITS-1:0] cfg_ind_duty;
    logic [7:0]          cfg_step;
    logic [7:0]          cfg_off;
    logic                led_tail_l;
    logic                led_tail_r;
    logic                led_brake;
    logic [NUM_SEG-1:0]  led_ind_l;
    logic [NUM_SEG-1:0]  led_ind_r;
    logic                seq_busy;
    logic [15:0]         cycle_count;

    modport master (
        output ctl_tail_en, ctl_brake, ctl_left, ctl_right, ctl_hazard,
        output cfg_tail_duty, cfg_brake_duty, cfg_ind_duty, cfg_step, cfg_off,
        input  led_tail_l, led_tail_r, led_brake, led_ind_l, led_ind_r,
        input  seq_busy, cycle_count
    );

    modport slave (
        input  ctl_tail_en, ctl_brake, ctl_left, ctl_right, ctl_hazard,
        input  cfg_tail_duty, cfg_brake_duty, cfg_ind_duty, cfg_step, cfg_off,
        output led_tail_l, led_tail_r, led_brake, led_ind_l, led_ind_r,
        output seq_busy, cycle_count
    );
endinterface

// File: rtl/rear_lights_sequencer.sv
// PWM tail/brake lamps and sweeping turn indicators; all pins registered, one cycle after counter/inputs.
// No backpressure: control bits are level inputs, indicator requests are sampled only in IDLE or at end of DARK.
module rear_lights_sequencer #(
    parameter int NUM_SEG  = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 200000
) (
    input  logic                  clock200_clk,
    input  logic                  reset_reset,
    rear_lights_sequencer_if.slave bus
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SEG_W = $clog2(NUM_SEG);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_HOLD,
        S_DARK
    } state_t;

    state_t              r_state;
    logic [SEG_W-1:0]    r_seg;
    logic [1:0]          r_side;
    logic [7:0]          r_timer;
    logic [15:0]         r_cycle_count;
    logic                r_busy;
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_led_tail_l;
    logic                r_led_tail_r;
    logic                r_led_brake;
    logic [NUM_SEG-1:0]  r_led_ind_l;
    logic [NUM_SEG-1:0]  r_led_ind_r;

    logic                w_tick;
    logic                w_expire;
    logic                w_req;
    logic [1:0]          w_side_req;
    logic [7:0]          w_step_load;
    logic [7:0]          w_off_load;
    logic [PWM_BITS-1:0] w_tail_duty;
    logic                w_pwm_ind;
    logic [NUM_SEG-1:0]  w_lit;

    assign w_tick      = (r_pre == PRE_LAST);
    assign w_expire    = w_tick && (r_timer == 8'd1);
    assign w_req       = bus.ctl_left | bus.ctl_right | bus.ctl_hazard;
    assign w_side_req  = (bus.ctl_hazard | (bus.ctl_left & bus.ctl_right)) ? 2'b11
                                                                         : {bus.ctl_right, bus.ctl_left};
    // A zero period would never expire, so it is treated as one tick.
    assign w_step_load = (bus.cfg_step == 8'd0) ? 8'd1 : bus.cfg_step;
    assign w_off_load  = (bus.cfg_off == 8'd0) ? 8'd1 : bus.cfg_off;

    // Brake overrides tail on the tail lamps.
    assign w_tail_duty = bus.ctl_brake   ? bus.cfg_brake_duty :
                         bus.ctl_tail_en ? bus.cfg_tail_duty  : '0;
    assign w_pwm_ind   = (r_pwm_cnt < bus.cfg_ind_duty);

    always_comb begin
        w_lit = '0;
        case (r_state)
            S_SWEEP: begin
                for (int i = 0; i < NUM_SEG; i++) begin
                    w_lit[i] = (SEG_W'(i) <= r_seg);
                end
            end
            S_HOLD:  w_lit = '1;
            default: w_lit = '0;
        endcase
    end

    always_ff @(posedge clock200_clk) begin
        if (reset_reset) begin
            r_pre        <= '0;
            r_pwm_cnt    <= '0;
            r_led_tail_l <= 1'b0;
            r_led_tail_r <= 1'b0;
            r_led_brake  <= 1'b0;
            r_led_ind_l  <= '0;
            r_led_ind_r  <= '0;
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            r_pwm_cnt    <= r_pwm_cnt + 1'b1;
            r_led_tail_l <= (r_pwm_cnt < w_tail_duty);
            r_led_tail_r <= (r_pwm_cnt < w_tail_duty);
            r_led_brake  <= bus.ctl_brake && (r_pwm_cnt < bus.cfg_brake_duty);
            r_led_ind_l  <= w_lit & {NUM_SEG{w_pwm_ind & r_side[0]}};
            r_led_ind_r  <= w_lit & {NUM_SEG{w_pwm_ind & r_side[1]}};
        end
    end

    always_ff @(posedge clock200_clk) begin
        if (reset_reset) begin
            r_state       <= S_IDLE;
            r_seg         <= '0;
            r_side        <= 2'b00;
            r_timer       <= 8'd0;
            r_cycle_count <= 16'd0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_side  <= w_side_req;
                        r_seg   <= '0;
                        r_timer <= w_step_load;
                        r_state <= S_SWEEP;
                        r_busy  <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_expire) begin
                        r_timer <= w_step_load;
                        if (r_seg == SEG_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_seg <= r_seg + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_expire) begin
                        r_timer <= w_off_load;
                        r_state <= S_DARK;
                    end else if (w_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_DARK: begin
                    if (w_expire) begin
                        r_cycle_count <= r_cycle_count + 16'd1;
                        // Requests are only re-examined here, so a started cycle always completes.
                        if (w_req) begin
                            r_side  <= w_side_req;
                            r_seg   <= '0;
                            r_timer <= w_step_load;
                            r_state <= S_SWEEP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led_tail_l  = r_led_tail_l;
    assign bus.led_tail_r  = r_led_tail_r;
    assign bus.led_brake   = r_led_brake;
    assign bus.led_ind_l   = r_led_ind_l;
    assign bus.led_ind_r   = r_led_ind_r;
    assign bus.seq_busy    = r_busy;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_rear_lights_sequencer.sv
// Directed bench for rear_lights_sequencer with PRESCALE=4 so a sweep step of 2 ticks lasts 8 clocks.
module tb_rear_lights_sequencer;
    localparam int NS = 8;
    localparam int PB = 8;
    localparam int PS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rear_lights_sequencer_if #(.NUM_SEG(NS), .PWM_BITS(PB)) bus ();

    rear_lights_sequencer #(.NUM_SEG(NS), .PWM_BITS(PB), .PRESCALE(PS)) dut (
        .clock200_clk (clk),
        .reset_reset  (rst),
        .bus          (bus.slave)
    );

    int          errors = 0;
    int          checks = 0;
    int          tcnt   = 0;
    logic [15:0] exp_cycles = 16'd0;

    // Clocks since reset release; equals the DUT PWM counter and prescaler phase.
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    // Expected lit mask j clocks after the sweep-start edge, sl = clocks per step.
    function automatic logic [7:0] exp_lit(int j, int sl);
        int         idx;
        logic [8:0] m;
        idx = j - 1;
        if (j < 1) return 8'h00;
        if (idx < 8 * sl) begin
            m = (9'd2 << (idx / sl)) - 9'd1;
            return m[7:0];
        end
        if (idx < 9 * sl) return 8'hFF;
        return 8'h00;
    endfunction

    // Pins sampled t clocks after reset show the PWM compare of counter value t-1.
    function automatic logic [7:0] pwm_gate(int t, logic [7:0] duty);
        logic [7:0] c;
        c = 8'(t - 1);
        return (c < duty) ? 8'hFF : 8'h00;
    endfunction

    task automatic align_tick;
        int k = 0;
        while ((tcnt % PS) != (PS - 1) && k < 8) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((tcnt % PS) != (PS - 1)) begin
            errors++;
            $display("FAIL align: phase=%0d required=%0d", tcnt % PS, PS - 1);
        end
    endtask

    task automatic test_reset;
        int nz = 0;
        rst = 1'b1;
        bus.ctl_tail_en = 0; bus.ctl_brake = 0; bus.ctl_left = 0; bus.ctl_right = 0; bus.ctl_hazard = 0;
        bus.cfg_tail_duty = 8'h80; bus.cfg_brake_duty = 8'h80; bus.cfg_ind_duty = 8'h80;
        bus.cfg_step = 8'd2; bus.cfg_off = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.led_tail_l, bus.led_tail_r, bus.led_brake, bus.led_ind_l, bus.led_ind_r, bus.seq_busy} !== '0
            || bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: tl=%b tr=%b br=%b il=%h ir=%h busy=%b cnt=%h required all 0",
                     bus.led_tail_l, bus.led_tail_r, bus.led_brake, bus.led_ind_l, bus.led_ind_r,
                     bus.seq_busy, bus.cycle_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({bus.led_tail_l, bus.led_tail_r, bus.led_brake, bus.led_ind_l, bus.led_ind_r, bus.seq_busy} !== '0
                || bus.cycle_count !== 16'd0) nz++;
        end
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL idle_quiet: nonzero samples=%0d required=0", nz);
        end
    endtask

    task automatic test_tail_brake;
        int tl, tr, br;
        logic [7:0] duties [3] = '{8'hFF, 8'h00, 8'h80};
        bus.ctl_tail_en = 1'b1; bus.cfg_tail_duty = 8'h40;
        @(negedge clk);
        tl = 0; tr = 0; br = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            tl += int'(bus.led_tail_l); tr += int'(bus.led_tail_r); br += int'(bus.led_brake);
        end
        checks++;
        if (tl !== 64 || tr !== 64) begin
            errors++;
            $display("FAIL tail_duty40: l=%0d r=%0d required 64", tl, tr);
        end
        checks++;
        if (br !== 0) begin
            errors++;
            $display("FAIL brake_off: brake highs=%0d required 0", br);
        end
        // Brake with duty FF, then 0; then brake with tail disabled at duty 80.
        bus.ctl_brake = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bus.cfg_brake_duty = duties[d];
            if (d == 2) bus.ctl_tail_en = 1'b0;
            @(negedge clk);
            tl = 0; tr = 0; br = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                tl += int'(bus.led_tail_l); tr += int'(bus.led_tail_r); br += int'(bus.led_brake);
            end
            checks++;
            if (tl !== int'(duties[d]) || tr !== int'(duties[d]) || br !== int'(duties[d])) begin
                errors++;
                $display("FAIL brake_duty%h: l=%0d r=%0d brake=%0d required %0d",
                         duties[d], tl, tr, br, duties[d]);
            end
        end
        bus.ctl_brake = 1'b0;
        @(negedge clk);
        tl = 0; br = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            tl += int'(bus.led_tail_l); br += int'(bus.led_brake);
        end
        checks++;
        if (tl !== 0 || br !== 0) begin
            errors++;
            $display("FAIL all_off: tail=%0d brake=%0d required 0", tl, br);
        end
    endtask

    task automatic test_left_sweep;
        logic [7:0]  el;
        logic [15:0] ec;
        bus.cfg_ind_duty = 8'hFF; bus.cfg_step = 8'd2; bus.cfg_off = 8'd3;
        align_tick();
        bus.ctl_left = 1'b1;
        @(negedge clk);
        bus.ctl_left = 1'b0;
        checks++;
        if (bus.seq_busy !== 1'b1) begin
            errors++;
            $display("FAIL left_busy_start: busy=%b required 1", bus.seq_busy);
        end
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            el = exp_lit(j, 8) & pwm_gate(tcnt, 8'hFF);
            ec = exp_cycles + ((j >= 84) ? 16'd1 : 16'd0);
            checks++;
            if (bus.led_ind_l !== el || bus.led_ind_r !== 8'h00 || bus.seq_busy !== (j < 84)
                || bus.cycle_count !== ec) begin
                errors++;
                $display("FAIL left_sweep j=%0d: l=%h r=%h busy=%b cnt=%0d required l=%h r=00 busy=%b cnt=%0d",
                         j, bus.led_ind_l, bus.led_ind_r, bus.seq_busy, bus.cycle_count, el, j < 84, ec);
            end
        end
        exp_cycles = exp_cycles + 16'd1;
    endtask

    task automatic test_hazard;
        logic [7:0]  el;
        logic [15:0] ec;
        align_tick();
        bus.ctl_hazard = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 256; j++) begin
            @(negedge clk);
            if (j == 168) bus.ctl_hazard = 1'b0;
            el = (j > 252) ? 8'h00 : exp_lit(((j - 1) % 84) + 1, 8) & pwm_gate(tcnt, 8'hFF);
            ec = exp_cycles + 16'(j / 84);
            checks++;
            if (bus.led_ind_l !== el || bus.led_ind_r !== el || bus.seq_busy !== (j < 252)
                || bus.cycle_count !== ec) begin
                errors++;
                $display("FAIL hazard j=%0d: l=%h r=%h busy=%b cnt=%0d required l=r=%h busy=%b cnt=%0d",
                         j, bus.led_ind_l, bus.led_ind_r, bus.seq_busy, bus.cycle_count, el, j < 252, ec);
            end
        end
        exp_cycles = exp_cycles + 16'd3;
    endtask

    task automatic test_right_drop;
        logic [7:0]  er;
        logic [15:0] ec;
        align_tick();
        bus.ctl_right = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            if (j == 20) bus.ctl_right = 1'b0;
            er = exp_lit(j, 8) & pwm_gate(tcnt, 8'hFF);
            ec = exp_cycles + ((j >= 84) ? 16'd1 : 16'd0);
            checks++;
            if (bus.led_ind_r !== er || bus.led_ind_l !== 8'h00 || bus.seq_busy !== (j < 84)
                || bus.cycle_count !== ec) begin
                errors++;
                $display("FAIL right_drop j=%0d: r=%h l=%h busy=%b cnt=%0d required r=%h l=00 busy=%b cnt=%0d",
                         j, bus.led_ind_r, bus.led_ind_l, bus.seq_busy, bus.cycle_count, er, j < 84, ec);
            end
        end
        exp_cycles = exp_cycles + 16'd1;
    endtask

    task automatic test_step_zero;
        logic [7:0]  el;
        logic [15:0] ec;
        bus.cfg_step = 8'd0; bus.cfg_off = 8'd0;
        align_tick();
        bus.ctl_left = 1'b1;
        @(negedge clk);
        bus.ctl_left = 1'b0;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            el = exp_lit(j, 4) & pwm_gate(tcnt, 8'hFF);
            ec = exp_cycles + ((j >= 40) ? 16'd1 : 16'd0);
            checks++;
            if (bus.led_ind_l !== el || bus.seq_busy !== (j < 40) || bus.cycle_count !== ec) begin
                errors++;
                $display("FAIL step_zero j=%0d: l=%h busy=%b cnt=%0d required l=%h busy=%b cnt=%0d",
                         j, bus.led_ind_l, bus.seq_busy, bus.cycle_count, el, j < 40, ec);
            end
        end
        exp_cycles = exp_cycles + 16'd1;
        bus.cfg_step = 8'd2; bus.cfg_off = 8'd3;
    endtask

    task automatic test_reset_in_hold;
        logic [7:0] el;
        align_tick();
        bus.ctl_left = 1'b1;
        @(negedge clk);
        bus.ctl_left = 1'b0;
        repeat (68) @(negedge clk);
        el = pwm_gate(tcnt, 8'hFF);
        checks++;
        if (bus.led_ind_l !== el || bus.seq_busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_reset: l=%h busy=%b required l=%h busy=1", bus.led_ind_l, bus.seq_busy, el);
        end
        bus.ctl_tail_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.led_tail_l, bus.led_tail_r, bus.led_brake, bus.led_ind_l, bus.led_ind_r, bus.seq_busy} !== '0
            || bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_hold: tl=%b il=%h ir=%h busy=%b cnt=%0d required all 0",
                     bus.led_tail_l, bus.led_ind_l, bus.led_ind_r, bus.seq_busy, bus.cycle_count);
        end
        rst = 1'b0;
        bus.ctl_tail_en = 1'b0;
        exp_cycles = 16'd0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.seq_busy !== 1'b0 || bus.led_ind_l !== 8'h00 || bus.cycle_count !== exp_cycles) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b l=%h cnt=%0d required busy=0 l=00 cnt=0",
                     bus.seq_busy, bus.led_ind_l, bus.cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_tail_brake();
        test_left_sweep();
        test_hazard();
        test_right_drop();
        test_step_zero();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rear_lights_sequencer.md
Name: rear_lights_sequencer

Overview:
Downstream consumer of the RearLights Avalon-MM register block. Takes the decoded control bits and duty/timing fields from that block and drives the physical rear-light outputs. Outputs are PWM tail/brake lamps and two NUM_SEG-segment sequential ("sweeping") turn indicators. Runs entirely in the clock200_clk domain.

Parameters:
NUM_SEG, 8, segments per indicator side (2..16)
PWM_BITS, 8, PWM counter/duty width
PRESCALE, 200000, clocks per timing tick (1 ms at 200 MHz); bench uses small values

Ports:
clock200_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
ctl_tail_en  in  1  tail lamps on
ctl_brake  in  1  brake active
ctl_left  in  1  left indicator request
ctl_right  in  1  right indicator request
ctl_hazard  in  1  hazard request (both sides)
cfg_tail_duty  in  PWM_BITS  tail lamp duty
cfg_brake_duty  in  PWM_BITS  brake duty (tail and brake lamps while braking)
cfg_ind_duty  in  PWM_BITS  indicator segment duty
cfg_step  in  8  sweep step period, ticks
cfg_off  in  8  dark period after sweep, ticks
led_tail_l  out  1  left tail PWM
led_tail_r  out  1  right tail PWM
led_brake  out  1  centre brake PWM
led_ind_l  out  NUM_SEG  left indicator segments, bit 0 = innermost
led_ind_r  out  NUM_SEG  right indicator segments
seq_busy  out  1  FSM not in IDLE
cycle_count  out  16  completed indicator cycles

Behaviour:
- Reset, synchronous: all outputs 0, FSM to IDLE, PWM counter 0, prescaler 0, timers 0, cycle_count 0. Asserting reset mid-sweep drives all outputs to 0 on the same edge.
- PWM: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0. Channel is high when counter < duty.
  - duty 0 -> constantly low.
  - duty 255 -> high 255 of 256 cycles.
  - All LED outputs are registered: one-cycle latency from counter/inputs to pins.
- Tail/brake priority:
  - led_tail_l/r use brake duty if ctl_brake, else tail duty if ctl_tail_en, else 0.
  - led_brake uses brake duty if ctl_brake, else 0.
- Tick: prescaler counts 0..PRESCALE-1. tick = 1 for one clock when the count is PRESCALE-1.
- Step timer: loads with max(cfg_*,1) on each state entry; decrements on tick; expires when it is 1 and tick occurs. cfg values are sampled only at load, so changes apply from the next load.
- Indicator FSM, states IDLE, SWEEP, HOLD, DARK:
  - IDLE: if ctl_left|ctl_right|ctl_hazard, latch side mask (hazard -> both; left and right together -> both), set seg=0, load cfg_step, go to SWEEP. Otherwise stay.
  - SWEEP: lit segments are bits 0..seg of each masked side. On timer expiry, seg++ and reload cfg_step. When expiry occurs at seg==NUM_SEG-1, go to HOLD and reload cfg_step.
  - HOLD: all NUM_SEG lit. On expiry, go to DARK and load cfg_off.
  - DARK: all unlit. On expiry, cycle_count++ (wraps 0xFFFF -> 0). Then, if a request is active, re-latch the mask, seg=0, go to SWEEP; else go to IDLE.
- Requests are ignored mid-cycle: a started cycle always completes, and dropping the request only takes effect at the end of DARK.
- Lit segment outputs = indicator PWM AND lit mask AND side mask. Unlit segments are 0.
- seq_busy = (state != IDLE), registered.

Test Plan:
- Reset, then all ctl=0, duties 0x80 -> all outputs 0, seq_busy 0, cycle_count 0 for 1000 clocks.
- ctl_tail_en=1, tail duty 0x40 -> led_tail_l/r high exactly 64 of every 256 clocks. Then ctl_brake=1, brake duty 0xFF -> high 255/256; led_brake matches.
- PRESCALE=4, cfg_step=2, cfg_off=3, ctl_left pulsed 1 clock -> led_ind_l lights bits 0..k, each step 8 clocks; full 0xFF held 8 clocks; dark 12 clocks; then IDLE, cycle_count=1; led_ind_r stays 0 throughout.
- ctl_hazard held -> both sides sweep identically and repeat continuously; cycle_count increments once per 84 clocks (8 steps + hold + dark).
- ctl_right dropped mid-SWEEP -> cycle completes fully, then IDLE. cfg_step=0 -> behaves as 1 tick.
- reset_reset asserted during HOLD -> next edge all outputs 0 and FSM IDLE. cycle_count preset near 0xFFFF via repeated cycles -> wraps to 0.
